regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two requesters: the pipeline writeback stage and a bulk loader (program/data preload, debug poke). Writeback has priority, and a starvation counter guarantees loader progress. Loader writes are buffered in a 4-entry FIFO. Sits directly in front of the register file write inputs (`write_address`, `write_data_in`, `WriteEnable`) and drives them from registered outputs.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_wr_fifo.sv | 52 +++++
 rtl/regfile_write_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default write data / register address widths
//   FIFO_DEPTH              : loader buffer depth
//   arb_state_t             : arbiter FSM state
//   ld_entry_t              : buffered loader write {addr, data}
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        WB_PRIO,
        LD_FORCE
    } arb_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } ld_entry_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/grant bundle between the two writers, the arbiter and the register file.
//   wb_*       : writeback request (valid/addr/data) and wb_ready
//   ld_*       : loader request (valid/addr/data) and ld_ready
//   rf_*       : registered register-file write port
//   ld_pending : loader FIFO occupancy
// master = requester/register-file side, slave = arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W-1:0] rf_write_address;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_WriteEnable;
    logic [2:0]        ld_pending;

    modport master (
        output wb_valid, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
        input  wb_ready, ld_ready, rf_write_address, rf_write_data,
               rf_WriteEnable, ld_pending
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
        output wb_ready, ld_ready, rf_write_address, rf_write_data,
               rf_WriteEnable, ld_pending
    );
endinterface

// File: rtl/regfile_wr_fifo.sv
// 4-deep first-in first-out buffer for loader writes.
//   clock, reset (async, active-high) : reset empties the buffer
//   push, push_entry                  : enqueue (ignored when full)
//   pop                               : dequeue (ignored when empty)
//   head                              : oldest entry
//   count, full, empty                : occupancy
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter type entry_t = ld_entry_t
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  entry_t     push_entry,
    input  logic       pop,
    output entry_t     head,
    output logic [2:0] count,
    output logic       full,
    output logic       empty
);
    entry_t     mem [FIFO_DEPTH];
    logic [1:0] wr_ptr, rd_ptr;
    logic       do_push, do_pop;

    assign full    = (count == 3'(FIFO_DEPTH));
    assign empty   = (count == 3'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between pipeline writeback
// (priority) and a buffered bulk loader. A starvation counter forces one loader
// write after STARVE_LIMIT writeback grants with loader data waiting.
//   clock, reset (async, active-high)
//   bus (slave) : wb_* / ld_* requests, registered rf_* write port, ld_pending
// Optional: define REGFILE_R0_PROTECT_EN to suppress writes to register 0
// (the grant is still consumed and the handshake still completes).
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    arb_state_t        state, state_nxt;
    logic [3:0]        starve, starve_nxt;
    entry_t            ld_in, ld_head;
    logic [2:0]        ld_count;
    logic              fifo_full, fifo_empty;
    logic              push, wb_ready, wb_grant, ld_grant, grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    assign ld_in         = '{addr: bus.ld_addr, data: bus.ld_data};
    // Registered count only: a pop this cycle never opens the FIFO early.
    assign bus.ld_ready   = (ld_count < 3'(FIFO_DEPTH));
    assign bus.ld_pending = ld_count;
    assign bus.wb_ready   = wb_ready;
    assign push           = bus.ld_valid && bus.ld_ready;

    regfile_wr_fifo #(.entry_t(entry_t)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (ld_in),
        .pop        (ld_grant),
        .head       (ld_head),
        .count      (ld_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve;
        wb_ready   = 1'b0;
        wb_grant   = 1'b0;
        ld_grant   = 1'b0;
        case (state)
            WB_PRIO: begin
                wb_ready = 1'b1;
                if (bus.wb_valid)     wb_grant = 1'b1;
                else if (!fifo_empty) ld_grant = 1'b1;
            end
            LD_FORCE: begin
                ld_grant  = !fifo_empty;
                state_nxt = WB_PRIO;
            end
            default: state_nxt = WB_PRIO;
        endcase
        // Count only writeback grants that overtook waiting loader data.
        if (ld_grant || fifo_empty) starve_nxt = 4'd0;
        else if (wb_grant)          starve_nxt = starve + 4'd1;
        if (state == WB_PRIO && starve_nxt >= 4'(STARVE_LIMIT)) state_nxt = LD_FORCE;
    end

    assign grant_addr = wb_grant ? bus.wb_addr : ld_head.addr;
    assign grant_data = wb_grant ? bus.wb_data : ld_head.data;

`ifdef REGFILE_R0_PROTECT_EN
    assign grant_we = (wb_grant || ld_grant) && (grant_addr != '0);
`else
    assign grant_we = wb_grant || ld_grant;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= WB_PRIO;
            starve <= 4'd0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
        end
    end

    // Address/data hold between grants so the register file sees a stable bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.rf_WriteEnable   <= 1'b0;
            bus.rf_write_address <= '0;
            bus.rf_write_data    <= '0;
        end else begin
            bus.rf_WriteEnable <= grant_we;
            if (wb_grant || ld_grant) begin
                bus.rf_write_address <= grant_addr;
                bus.rf_write_data    <= grant_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] max_pend;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    initial begin
        int c, k, zero_cycles, budget;
        logic rdy;

        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        max_pend = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clock);
                if (bus.ld_pending > max_pend) max_pend = bus.ld_pending;
                if (!reset && bus.rf_WriteEnable) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: addr %0d data 0x%0h at cyc %0d, none expected",
                                 bus.rf_write_address, bus.rf_write_data, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", 64'(bus.rf_write_address), 64'(e.addr));
                        check("wr_data", 64'(bus.rf_write_data), 64'(e.data));
                        check("wr_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        join_none

        // Reset values
        tick();
        check("rst_we", 64'(bus.rf_WriteEnable), 64'd0);
        check("rst_addr", 64'(bus.rf_write_address), 64'd0);
        check("rst_data", 64'(bus.rf_write_data), 64'd0);
        check("rst_wb_ready", 64'(bus.wb_ready), 64'd1);
        check("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
        check("rst_pending", 64'(bus.ld_pending), 64'd0);
        reset = 1'b0;
        tick();

        // Writeback only
        c = cyc;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEADBEEF;
        expect_wr(5'd3, 32'hDEADBEEF, c + 1);
        tick();
        bus.wb_valid = 1'b0;
        check("wb_we_high", 64'(bus.rf_WriteEnable), 64'd1);
        tick();
        check("wb_we_low", 64'(bus.rf_WriteEnable), 64'd0);
        tick();

        // Loader only, 5 back-to-back pushes
        c = cyc;
        max_pend = '0;
        for (int i = 0; i < 5; i++) begin
            check("ld_ready_b2b", 64'(bus.ld_ready), 64'd1);
            bus.ld_valid = 1'b1; bus.ld_addr = 5'(8 + i); bus.ld_data = 32'(100 + i);
            expect_wr(5'(8 + i), 32'(100 + i), c + 2 + i);
            tick();
        end
        bus.ld_valid = 1'b0;
        repeat (4) tick();
        check("ld_max_pending", 64'(max_pend), 64'd1);

        // FIFO fill under continuous writeback
        c = cyc;
        bus.wb_valid = 1'b1; bus.ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wb_addr = 5'(16 + i); bus.wb_data = 32'hA0 + 32'(i);
            bus.ld_addr = 5'(20 + i); bus.ld_data = 32'hB0 + 32'(i);
            expect_wr(5'(16 + i), 32'hA0 + 32'(i), c + 1 + i);
            tick();
        end
        check("fill_pending", 64'(bus.ld_pending), 64'd4);
        check("fill_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("fill_wb_ready", 64'(bus.wb_ready), 64'd1);
        bus.wb_valid = 1'b0; bus.ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) expect_wr(5'(20 + i), 32'hB0 + 32'(i), c + 5 + i);
        repeat (6) tick();
        check("drain_pending", 64'(bus.ld_pending), 64'd0);

        // Starvation: one pending loader entry vs 10 writebacks
        c = cyc;
        for (int i = 0; i < 10; i++)
            if (i < 5) expect_wr(5'(10 + i), 32'hC00 + 32'(i), c + 1 + i);
            else if (i == 5) begin
                expect_wr(5'd30, 32'h5A5A, c + 6);
                expect_wr(5'(10 + i), 32'hC00 + 32'(i), c + 2 + i);
            end else expect_wr(5'(10 + i), 32'hC00 + 32'(i), c + 2 + i);
        k = 0; zero_cycles = 0; budget = 0;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd30; bus.ld_data = 32'h5A5A;
        while (k < 10 && budget < 30) begin
            bus.wb_valid = 1'b1; bus.wb_addr = 5'(10 + k); bus.wb_data = 32'hC00 + 32'(k);
            rdy = bus.wb_ready;
            if (!rdy) zero_cycles++;
            tick();
            bus.ld_valid = 1'b0;
            if (rdy) k++;
            budget++;
        end
        bus.wb_valid = 1'b0;
        check("starve_wb_done", 64'(k), 64'd10);
        check("starve_wb_ready_low_cycles", 64'(zero_cycles), 64'd1);
        repeat (3) tick();

        // Reset mid-operation with 3 buffered entries and a write in flight
        c = cyc;
        bus.wb_valid = 1'b1; bus.ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wb_addr = 5'(21 + i); bus.wb_data = 32'hE0 + 32'(i);
            bus.ld_addr = 5'(24 + i); bus.ld_data = 32'hF0 + 32'(i);
            if (i < 2) expect_wr(5'(21 + i), 32'hE0 + 32'(i), c + 1 + i);
            tick();
        end
        bus.wb_valid = 1'b0; bus.ld_valid = 1'b0;
        check("pre_rst_pending", 64'(bus.ld_pending), 64'd3);
        check("pre_rst_we", 64'(bus.rf_WriteEnable), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_we", 64'(bus.rf_WriteEnable), 64'd0);
        check("async_rst_addr", 64'(bus.rf_write_address), 64'd0);
        check("async_rst_data", 64'(bus.rf_write_data), 64'd0);
        check("async_rst_pending", 64'(bus.ld_pending), 64'd0);
        check("async_rst_ld_ready", 64'(bus.ld_ready), 64'd1);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        // Writes to register 0
        c = cyc;
`ifdef REGFILE_R0_PROTECT_EN
        expect_wr(5'd1, 32'h2222, c + 2);
`else
        expect_wr(5'd0, 32'h1111, c + 1);
        expect_wr(5'd1, 32'h2222, c + 2);
`endif
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1111;
        check("r0_wb_ready", 64'(bus.wb_ready), 64'd1);
        tick();
`ifdef REGFILE_R0_PROTECT_EN
        check("r0_we", 64'(bus.rf_WriteEnable), 64'd0);
`else
        check("r0_we", 64'(bus.rf_WriteEnable), 64'd1);
`endif
        check("r1_wb_ready", 64'(bus.wb_ready), 64'd1);
        bus.wb_addr = 5'd1; bus.wb_data = 32'h2222;
        tick();
        bus.wb_valid = 1'b0;
        check("r1_we", 64'(bus.rf_WriteEnable), 64'd1);
        repeat (3) tick();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
